fifo_stream_reader: RTL and testbench

Read-side controller for the team's synchronous 8-bit `fifo`. It pops words from the FIFO whenever the FIFO holds data and local space exists, absorbing the FIFO's one-cycle read latency. It re-presents the words on a valid/ready stream for downstream consumers. A 3-entry local buffer keeps throughput at one word per clock under continuous `m_ready`, with no combinational path from `m_ready` to `read`.

---
 rtl/fifo_stream_reader.sv | 146 ++++++++++++++
 tb/tb_fifo_stream_reader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous 8-bit fifo: pops words, hides the
// one-cycle read latency in a 3-entry buffer and re-presents them as a stream.
module fifo_stream_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] data_out,
    output logic             read,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] buf_mem [3];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [1:0]       count;
    logic             inflight;
    logic [2:0]       occupancy;
    logic             capture;
    logic             xfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words held locally plus the one still coming back from the FIFO.
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    assign capture   = inflight;
    assign m_valid   = (count != 2'd0);
    assign m_data    = buf_mem[rd_ptr];
    assign xfer      = m_valid && m_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (en) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (!en) begin
                    if ((count != 2'd0) || inflight || xfer) state_nxt = DRAIN;
                    else                                     state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (en)                                   state_nxt = ACTIVE;
                else if ((count == 2'd0) && !inflight)    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; read never looks at m_ready, only at registered occupancy.
    always_comb begin
        read = 1'b0;
        busy = 1'b0;
        unique case (state)
            ACTIVE: begin
                busy = 1'b1;
                read = en && !empty && (occupancy < 3'd3);
            end
            DRAIN: begin
                busy = 1'b1;
            end
            default: begin
                read = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= read;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (capture) begin
            buf_mem[wr_ptr] <= data_out;
            wr_ptr          <= ptr_inc(wr_ptr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
        end else if (xfer) begin
            rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            unique case ({capture, xfer})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            words_sent <= '0;
        end else if (xfer) begin
            words_sent <= words_sent + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO model and a
// second 4-bit-counter instance for the wrap check.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        empty;
    logic [7:0]  data_out = 8'h00;
    logic        read;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        busy;
    logic [15:0] words_sent;

    logic        en2;
    logic [7:0]  data_out2 = 8'h00;
    logic        read2;
    logic        m_valid2;
    logic [7:0]  m_data2;
    logic        busy2;
    logic [3:0]  words_sent2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [256];
    int wr_idx = 0;
    int rd_idx = 0;
    logic read_while_empty = 1'b0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .empty(empty), .data_out(data_out),
        .read(read), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .words_sent(words_sent)
    );

    fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) dut_wrap (
        .clk(clk), .reset(reset), .en(en2), .empty(1'b0), .data_out(data_out2),
        .read(read2), .m_valid(m_valid2), .m_data(m_data2), .m_ready(1'b1),
        .busy(busy2), .words_sent(words_sent2)
    );

    // FIFO model: a read with data present updates data_out at the same edge.
    assign empty = (rd_idx == wr_idx);

    always @(posedge clk) begin
        if (read && !empty) begin
            data_out <= mem[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    always @(posedge clk) begin
        if (read2) data_out2 <= data_out2 + 8'h01;
    end

    always @(negedge clk) begin
        if (read && empty) read_while_empty <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_idx] = d;
        wr_idx = wr_idx + 1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        en      = 1'b0;
        m_ready = 1'b0;
        wr_idx  = rd_idx;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int seen;
        logic pend;

        reset   = 1'b1;
        en      = 1'b0;
        m_ready = 1'b0;
        en2     = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_read",   read,       0);
        chk("rst_valid",  m_valid,    0);
        chk("rst_data",   m_data,     0);
        chk("rst_busy",   busy,       0);
        chk("rst_words",  words_sent, 0);

        // Basic stream
        push(8'h11); push(8'h22); push(8'h33);
        reset = 1'b0;
        @(negedge clk);
        en = 1'b1; m_ready = 1'b1;
        @(negedge clk); chk("bs_read1", read, 1); chk("bs_valid1", m_valid, 0);
        @(negedge clk); chk("bs_read2", read, 1); chk("bs_valid2", m_valid, 0);
        @(negedge clk); chk("bs_read3", read, 1); chk("bs_valid3", m_valid, 1); chk("bs_data0", m_data, 8'h11);
        @(negedge clk); chk("bs_read4", read, 0); chk("bs_data1", m_data, 8'h22);
        @(negedge clk); chk("bs_read5", read, 0); chk("bs_data2", m_data, 8'h33);
        @(negedge clk); chk("bs_valid_end", m_valid, 0); chk("bs_words", words_sent, 3);

        // Backpressure
        do_reset();
        push(8'h50); push(8'h51); push(8'h52); push(8'h53); push(8'h54);
        en = 1'b1; m_ready = 1'b0;
        @(negedge clk); chk("bp_read1", read, 1);
        @(negedge clk); chk("bp_read2", read, 1);
        @(negedge clk); chk("bp_read3", read, 1); chk("bp_data_a", m_data, 8'h50);
        @(negedge clk); chk("bp_read4", read, 0); chk("bp_data_b", m_data, 8'h50);
        @(negedge clk); chk("bp_read5", read, 0); chk("bp_data_c", m_data, 8'h50);
        @(negedge clk); chk("bp_read6", read, 0); chk("bp_valid_hold", m_valid, 1); chk("bp_data_d", m_data, 8'h50);
        m_ready = 1'b1;
        @(negedge clk); chk("bp_read7", read, 1); chk("bp_data1", m_data, 8'h51);
        @(negedge clk); chk("bp_read8", read, 1); chk("bp_data2", m_data, 8'h52);
        @(negedge clk); chk("bp_valid3", m_valid, 1); chk("bp_data3", m_data, 8'h53);
        @(negedge clk); chk("bp_valid4", m_valid, 1); chk("bp_data4", m_data, 8'h54);
        @(negedge clk); chk("bp_valid_end", m_valid, 0); chk("bp_words", words_sent, 5);

        // Drain on en drop
        do_reset();
        push(8'h60); push(8'h61); push(8'h62); push(8'h63);
        en = 1'b1; m_ready = 1'b1;
        @(negedge clk); chk("dr_read1", read, 1);
        @(negedge clk); chk("dr_read2", read, 1);
        @(negedge clk); chk("dr_data0", m_data, 8'h60);
        en = 1'b0;
        #1 chk("dr_read_gated", read, 0);
        @(negedge clk); chk("dr_read4", read, 0); chk("dr_data1", m_data, 8'h61); chk("dr_busy4", busy, 1);
        @(negedge clk); chk("dr_valid5", m_valid, 0); chk("dr_busy5", busy, 1);
        @(negedge clk); chk("dr_busy6", busy, 0); chk("dr_words", words_sent, 2);
        chk("dr_fifo_left", wr_idx - rd_idx, 2);

        // Empty gaps
        do_reset();
        push(8'hA0);
        en = 1'b1; m_ready = 1'b1;
        @(negedge clk); chk("eg_read1", read, 1);
        @(negedge clk); chk("eg_read2", read, 0); chk("eg_valid2", m_valid, 0);
        @(negedge clk); chk("eg_valid3", m_valid, 1); chk("eg_data0", m_data, 8'hA0);
        push(8'hA1);
        @(negedge clk); chk("eg_valid4", m_valid, 0);
        @(negedge clk); chk("eg_valid5", m_valid, 1); chk("eg_data1", m_data, 8'hA1);
        @(negedge clk); chk("eg_valid6", m_valid, 0);
        push(8'hA2);
        @(negedge clk); chk("eg_valid7", m_valid, 0);
        @(negedge clk); chk("eg_valid8", m_valid, 1); chk("eg_data2", m_data, 8'hA2);
        @(negedge clk); chk("eg_valid9", m_valid, 0); chk("eg_words", words_sent, 3);

        // Reset mid-stream with count=2 and a word in flight
        do_reset();
        push(8'h70); push(8'h71); push(8'h72); push(8'h73); push(8'h74);
        en = 1'b1; m_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("rm_valid_pre", m_valid, 1); chk("rm_read_pre", read, 0);
        #2 reset = 1'b1;
        #1;
        chk("rm_valid", m_valid, 0); chk("rm_read", read, 0);
        chk("rm_busy", busy, 0); chk("rm_words", words_sent, 0); chk("rm_data", m_data, 0);
        @(negedge clk);
        reset = 1'b0; m_ready = 1'b1;
        @(negedge clk); chk("rm_read6", read, 1);
        @(negedge clk); chk("rm_read7", read, 1);
        @(negedge clk); chk("rm_data0", m_data, 8'h73); chk("rm_read8", read, 0);
        @(negedge clk); chk("rm_data1", m_data, 8'h74);
        @(negedge clk); chk("rm_valid_end", m_valid, 0); chk("rm_words2", words_sent, 2);

        // Counter wrap on the 4-bit instance
        do_reset();
        en2  = 1'b1;
        seen = 0;
        pend = 1'b0;
        for (int c = 0; c < 100 && seen < 17; c++) begin
            @(negedge clk);
            if (pend) begin
                seen++;
                if (seen == 16) chk("wrap_16", words_sent2, 0);
                if (seen == 17) chk("wrap_17", words_sent2, 1);
            end
            pend = m_valid2;
        end
        chk("wrap_reached", seen, 17);
        en2 = 1'b0;

        chk("no_read_while_empty", read_while_empty, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
